fir_decim_outbuf: RTL and testbench
===================================

Name: fir_decim_outbuf

Overview:
- Downstream consumer of the lowpass FIR stage.
- Captures each signed FIR result when the FIR's done strobe pulses, discards a programmable start-up transient, decimates by DECIM, and applies a saturating power-of-two gain.
- Buffers samples in a small first-word-fall-through FIFO and presents them on a valid/ready stream to the next processing block.

Parameters:
- DATA_WIDTH, 16: width of fir_result and out_data, two's complement.
- DECIM, 4: decimation factor, keep 1 of every DECIM accepted results; range 1..256.
- FLUSH_CNT, 32: FIR results discarded after enable, covering the filter transient; range 0..65535.
- GAIN_SHIFT, 0: left shift applied before saturation; range 0..7.
- FIFO_DEPTH, 8: FIFO entries, power of two, minimum 2.
- Shared package constant LVL_W = $clog2(FIFO_DEPTH)+1.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: reset, asynchronous assert, active-low, synchronous deassert handled upstream.
- en, in, 1: run enable.
- fir_result, in, DATA_WIDTH: FIR output sample.
- fir_done, in, 1: one-cycle strobe, fir_result valid in the same cycle.
- out_data, out, DATA_WIDTH: head-of-FIFO sample.
- out_valid, out, 1: FIFO non-empty.
- out_ready, in, 1: consumer accepts; a pop occurs when out_valid && out_ready.
- fifo_level, out, LVL_W: current FIFO occupancy.
- ovf, out, 1: sticky overflow, set when a push is attempted while the FIFO is full.
- clr_ovf, in, 1: synchronous clear of ovf.
- busy, out, 1: high in FLUSH or RUN.

Behaviour:
- Reset (rst=0):
  - State = IDLE.
  - Flush counter, decimation counter, FIFO pointers and stage register cleared.
  - Outputs: out_data=0, out_valid=0, fifo_level=0, ovf=0, busy=0.
- FSM with 3 states:
  - IDLE: fir_done ignored. en=1 moves to FLUSH, or straight to RUN if FLUSH_CNT=0.
  - FLUSH: each fir_done increments the flush counter and the sample is discarded. When the count reaches FLUSH_CNT, move to RUN with the decimation counter at 0.
  - RUN: each fir_done increments the decimation counter modulo DECIM. The sample is kept when the counter equals 0 before the increment, so the first RUN sample is kept.
  - en=0 in any state: next cycle goes to IDLE and clears the flush and decimation counters. FIFO contents are retained and keep draining.
- Arithmetic, pipeline stage 1:
  - s = sign-extended fir_result << GAIN_SHIFT.
  - If s > 2^(DATA_WIDTH-1)-1, clamp to max. If s < -2^(DATA_WIDTH-1), clamp to min.
  - The result is registered together with a push flag.
- Stage 2: push into FIFO.
- Latency: kept fir_done in cycle 0 gives out_valid=1 and the sample on out_data in cycle 2, when the FIFO was empty.
- FIFO rules:
  - Push while full and no pop in the same cycle: sample dropped, ovf set, level unchanged.
  - Push and pop in the same cycle while full: both occur, level unchanged, no ovf.
  - Pop while empty is impossible because out_valid=0.
  - out_data is held stable while out_valid && !out_ready.
- ovf:
  - clr_ovf and an overflow event in the same cycle: ovf stays set (set wins).
- Reset mid-operation: all state discarded immediately, including FIFO contents and any in-flight stage-1 sample.
- fir_done held high for multiple cycles: each cycle counts as a separate result. The FIR produces single-cycle strobes.

Optional Feature:
- Macro FIR_DECIM_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, out, 16: saturating count of samples lost to overflow.
  - Cleared by reset and by clr_ovf.
  - A same-cycle drop wins over clr_ovf and leaves drop_cnt=1.
- Undefined: port absent, no counter logic. All other behaviour is identical.

Decomposition:
- Package fir_decim_pkg: LVL_W function/constant, state enum (IDLE=2'd0, FLUSH=2'd1, RUN=2'd2), sat_shift function (width-generic saturating shift).
- One sub-module, sync_fifo_fwft, parameterised by width and depth. Exports level, full and empty.
- FSM, counters and gain stage stay in the top module.

Test Plan:
- FLUSH_CNT=2, DECIM=4, en=1, fir_done strobes with values 1..10 on every 3rd cycle, out_ready=1 -> values 1,2 discarded; out stream is 3, 7. Each sample appears exactly 2 cycles after its fir_done.
- GAIN_SHIFT=2, inputs 0x1000, 0x3000, 0xC000, 0x8001 -> outputs 0x4000, 0x7FFF, 0x8000, 0x8000.
- DECIM=1, FIFO_DEPTH=8, out_ready=0, 10 kept samples -> fifo_level reaches 8, ovf=1, samples 9 and 10 lost. Then out_ready=1 drains exactly the first 8 in order. With FIR_DECIM_DROP_CNT_EN, drop_cnt=2.
- FIFO full, out_ready=1 and a push in the same cycle -> level stays 8, ovf stays 0.
- Drop en mid-RUN, then re-assert -> FLUSH repeats; FIFO data already queued is still delivered intact.
- Assert rst low mid-stream with the FIFO holding 5 -> the same cycle (asynchronous) gives out_valid=0, fifo_level=0, ovf=0, busy=0. After release, no stale samples appear.

Source files
------------

// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: shared types, FIFO level width and the saturating gain helper
package fir_decim_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RUN = 2'd2} state_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int LVL_W = lvl_w(8);
  // x must already be sign-extended; the result fits in w bits after clamping
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x, input int sh, input int w);
    logic signed [63:0] s, mx, mn;
    s = x <<< sh;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return s > mx ? mx : s < mn ? mn : s;
  endfunction
endpackage

// File: rtl/fir_decim_outbuf_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO with occupancy, full and empty
//   push/din write when not full or when popping in the same cycle
//   pop/dout read the head; dout reads 0 while empty
//   rst is asynchronous active-low and empties the FIFO
module sync_fifo_fwft import fir_decim_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = level == lvl_w(DEPTH)'(DEPTH);
  assign empty = level == '0;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      level <= level + lvl_w(DEPTH)'(wr) - lvl_w(DEPTH)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/fir_decim_outbuf.sv
// fir_decim_outbuf: flushes, decimates and gain-saturates FIR results into a valid/ready stream
//   en, fir_result, fir_done: run enable and FIR sample strobe
//   out_data, out_valid, out_ready, fifo_level: buffered output stream
//   ovf, clr_ovf: sticky overflow flag and its clear; busy: in FLUSH or RUN
//   rst: asynchronous active-low reset
//   FIR_DECIM_DROP_CNT_EN adds drop_cnt, a saturating count of overflow losses
module fir_decim_outbuf import fir_decim_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int FLUSH_CNT  = 32,
  parameter int GAIN_SHIFT = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [DATA_WIDTH-1:0]           fir_result,
  input  logic                            fir_done,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [lvl_w(FIFO_DEPTH)-1:0]    fifo_level,
  output logic                            ovf,
  input  logic                            clr_ovf,
  output logic                            busy
`ifdef FIR_DECIM_DROP_CNT_EN
  , output logic [15:0]                   drop_cnt
`endif
);
  state_t state;
  logic [15:0] flush_cnt;
  logic [7:0] dec_cnt;
  logic stg_vld, keep, full, empty, pop, drop;
  logic [DATA_WIDTH-1:0] stg_data;
  assign keep = state == RUN && fir_done && dec_cnt == '0;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign drop = stg_vld && full && !pop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      flush_cnt <= '0;
      dec_cnt <= '0;
      busy <= 1'b0;
      stg_vld <= 1'b0;
      stg_data <= '0;
    end else begin
      stg_vld <= keep;
      stg_data <= DATA_WIDTH'(sat_shift(64'(signed'(fir_result)), GAIN_SHIFT, DATA_WIDTH));
      if (!en) begin
        state <= IDLE;
        flush_cnt <= '0;
        dec_cnt <= '0;
        busy <= 1'b0;
      end else case (state)
        IDLE: begin
          state <= FLUSH_CNT == 0 ? RUN : FLUSH;
          dec_cnt <= '0;
          busy <= 1'b1;
        end
        FLUSH: if (fir_done) begin
          state <= flush_cnt == 16'(FLUSH_CNT - 1) ? RUN : FLUSH;
          flush_cnt <= flush_cnt == 16'(FLUSH_CNT - 1) ? '0 : flush_cnt + 16'd1;
          dec_cnt <= '0;
        end
        RUN: if (fir_done) dec_cnt <= dec_cnt == 8'(DECIM - 1) ? '0 : dec_cnt + 8'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  // a drop in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf <= 1'b0;
    else ovf <= drop ? 1'b1 : clr_ovf ? 1'b0 : ovf;
`ifdef FIR_DECIM_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) drop_cnt <= '0;
    else drop_cnt <= drop ? (clr_ovf ? 16'd1 : drop_cnt == 16'hFFFF ? drop_cnt : drop_cnt + 16'd1)
                          : clr_ovf ? '0 : drop_cnt;
`endif
  sync_fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(stg_vld),
    .din(stg_data),
    .pop(pop),
    .dout(out_data),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_fir_decim_outbuf.sv
// tb_fir_decim_outbuf: scoreboard bench for two fir_decim_outbuf configurations
module tb_fir_decim_outbuf;
  typedef struct {logic [15:0] d; int due;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int checks = 0, errors = 0, cyc = 0;
  logic clk = 0, rst = 0;
  logic a_en = 0, a_done = 0, a_ready = 0, a_clr = 0;
  logic b_en = 0, b_done = 0, b_ready = 0, b_clr = 0;
  logic [15:0] a_res = 0, b_res = 0, a_data, b_data;
  logic a_valid, b_valid, a_ovf, b_ovf, a_busy, b_busy;
  logic [3:0] a_level, b_level;
`ifdef FIR_DECIM_DROP_CNT_EN
  logic [15:0] a_drop, b_drop;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_decim_outbuf #(.DATA_WIDTH(16), .DECIM(4), .FLUSH_CNT(2), .GAIN_SHIFT(0), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .fir_result(a_res), .fir_done(a_done),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready), .fifo_level(a_level),
    .ovf(a_ovf), .clr_ovf(a_clr), .busy(a_busy)
`ifdef FIR_DECIM_DROP_CNT_EN
    , .drop_cnt(a_drop)
`endif
  );

  fir_decim_outbuf #(.DATA_WIDTH(16), .DECIM(1), .FLUSH_CNT(0), .GAIN_SHIFT(2), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .fir_result(b_res), .fir_done(b_done),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .fifo_level(b_level),
    .ovf(b_ovf), .clr_ovf(b_clr), .busy(b_busy)
`ifdef FIR_DECIM_DROP_CNT_EN
    , .drop_cnt(b_drop)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe_a(input logic [15:0] v);
    a_res = v; a_done = 1; tick(1); a_done = 0;
  endtask

  task automatic strobe_b(input logic [15:0] v);
    b_res = v; b_done = 1; tick(1); b_done = 0;
  endtask

  always @(negedge clk)
    if (rst && a_valid && a_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: got %h expected nothing", a_data);
      end else begin
        ea = qa.pop_front();
        if (a_data !== ea.d || (ea.due >= 0 && cyc != ea.due)) begin
          errors++;
          $display("FAIL a_out: got %h at cycle %0d expected %h at cycle %0d", a_data, cyc, ea.d, ea.due);
        end
      end
    end

  always @(negedge clk)
    if (rst && b_valid && b_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got %h expected nothing", b_data);
      end else begin
        eb = qb.pop_front();
        if (b_data !== eb.d || (eb.due >= 0 && cyc != eb.due)) begin
          errors++;
          $display("FAIL b_out: got %h at cycle %0d expected %h at cycle %0d", b_data, cyc, eb.d, eb.due);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] gin [7] = '{16'h1000, 16'h3000, 16'hC000, 16'h8001, 16'hFFFF, 16'h1FFF, 16'hE000};
    logic [15:0] gout [7] = '{16'h4000, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFC, 16'h7FFC, 16'h8000};
    tick(2);
    chk("rst_valid", a_valid, 0);
    chk("rst_level", a_level, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_data", a_data, 0);
    rst = 1;
    tick(1);
    // flush 2, keep 1 of 4: values 3 and 7 survive, 2 cycles after their strobe
    a_en = 1; a_ready = 1;
    tick(2);
    chk("a_busy_flush", a_busy, 1);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3 || i == 7) qa.push_back('{16'(i), cyc + 2});
      strobe_a(16'(i));
      tick(2);
    end
    tick(4);
    chk("a_stream_done", qa.size(), 0);
    // gain of 4 with saturation at both rails
    b_en = 1; b_ready = 1;
    tick(2);
    chk("b_busy_run", b_busy, 1);
    for (int i = 0; i < 7; i++) begin
      qb.push_back('{gout[i], cyc + 2});
      strobe_b(gin[i]);
    end
    tick(4);
    chk("b_gain_done", qb.size(), 0);
    // overflow: 10 kept samples into 8 entries with the consumer stalled
    b_ready = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) qb.push_back('{16'(k * 4), -1});
      strobe_b(16'(k));
    end
    tick(3);
    chk("b_full_level", b_level, 8);
    chk("b_ovf_set", b_ovf, 1);
    chk("b_head_held", b_data, 16'h0004);
    chk("b_valid_full", b_valid, 1);
`ifdef FIR_DECIM_DROP_CNT_EN
    chk("b_drop_2", b_drop, 2);
`endif
    // drop and clr_ovf together: the drop wins
    strobe_b(16'd99);
    b_clr = 1; tick(1); b_clr = 0;
    chk("b_ovf_setwins", b_ovf, 1);
`ifdef FIR_DECIM_DROP_CNT_EN
    chk("b_drop_setwins", b_drop, 1);
`endif
    b_clr = 1; tick(1); b_clr = 0;
    chk("b_ovf_clr", b_ovf, 0);
`ifdef FIR_DECIM_DROP_CNT_EN
    chk("b_drop_clr", b_drop, 0);
`endif
    // push and pop together while full
    qb.push_back('{16'd44, -1});
    strobe_b(16'd11);
    b_ready = 1;
    tick(1);
    chk("b_pushpop_level", b_level, 8);
    chk("b_pushpop_ovf", b_ovf, 0);
    tick(12);
    chk("b_drained", b_level, 0);
    chk("b_drain_q", qb.size(), 0);
    // en dropped mid-RUN: flush repeats, queued data survives
    a_ready = 0;
    qa.push_back('{16'd100, -1});
    strobe_a(16'd100); tick(2);
    strobe_a(16'd101); tick(3);
    chk("a_level_1", a_level, 1);
    a_en = 0; tick(2);
    chk("a_busy_off", a_busy, 0);
    a_en = 1; tick(2);
    chk("a_busy_again", a_busy, 1);
    strobe_a(16'd200); tick(2);
    strobe_a(16'd201); tick(2);
    qa.push_back('{16'd202, -1});
    strobe_a(16'd202); tick(2);
    strobe_a(16'd203); tick(3);
    chk("a_level_2", a_level, 2);
    chk("a_head_kept", a_data, 16'd100);
    a_ready = 1; tick(5);
    chk("a_redrain", a_level, 0);
    // asynchronous reset with 5 queued and one sample in flight
    b_ready = 0;
    for (int k = 1; k <= 5; k++) strobe_b(16'(k));
    tick(3);
    chk("b_level_5", b_level, 5);
    strobe_b(16'd6);
    #1 rst = 0;
    #1;
    chk("arst_valid", b_valid, 0);
    chk("arst_level", b_level, 0);
    chk("arst_ovf", b_ovf, 0);
    chk("arst_busy", b_busy, 0);
    chk("arst_data", b_data, 0);
    tick(1);
    rst = 1;
    b_ready = 1;
    tick(10);
    chk("post_rst_level", b_level, 0);
    chk("post_rst_valid", b_valid, 0);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
